// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit format, packet geometry, error codes and receive FSM
// states shared by the NoC injector and ejection sides.
package noc_flit_pkg;

  localparam int FLIT_W    = 20;
  localparam int PAYLOAD_W = FLIT_W - 2;
  localparam int PKT_LEN   = 30;
  localparam int ADDR_W    = 5;

  // Flit type field, top two bits of every flit
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_RSVD = 2'b11;

  // Receive error codes
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SEQ  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_CSUM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DONE,
    ST_ERR
  } rx_state_t;

  function automatic logic [1:0] flit_type_of(input logic [FLIT_W-1:0] flit);
    return flit[FLIT_W-1 -: 2];
  endfunction

endpackage

// File: rtl/datain_ram.sv
// datain_ram: packet buffer with synchronous write and a registered,
// read-first read port. Out-of-range read addresses return zero.
module datain_ram #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 30,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset so packets persist
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read sees the pre-write value on a same-address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rd_data <= '0;
    else if (rd_addr < AW'(DEPTH)) rd_data <= mem[rd_addr];
    else                          rd_data <= '0;
  end

endmodule

// File: rtl/datain_buf.sv
// datain_buf: ejection-side packet sink. Captures one fixed-length packet,
// checks flit sequence, length and payload XOR checksum, and exposes the
// stored flits through a registered read port.
module datain_buf
  import noc_flit_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic              enable,
  input  logic [FLIT_W-1:0] datain,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [FLIT_W-1:0] rd_data,
  output logic              rx_done,
  output logic              rx_err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] flit_cnt,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(PKT_LEN - 1);

  rx_state_t state, state_next;

  logic [PAYLOAD_W-1:0] acc, acc_next;
  logic [PAYLOAD_W-1:0] payload;
  logic [1:0]           ftype;
  logic [ADDR_W-1:0]    cnt_next;
  logic [1:0]           code_next;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 done_next, err_next, busy_next;

  assign payload = datain[PAYLOAD_W-1:0];
  assign ftype   = flit_type_of(datain);

  // State register; async reset discards any packet in flight
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next state plus buffer write, flit count, checksum and error decisions
  always_comb begin
    state_next = state;
    cnt_next   = flit_cnt;
    acc_next   = acc;
    code_next  = err_code;
    wr_en      = 1'b0;
    wr_addr    = '0;
    case (state)
      ST_IDLE: begin
        if (enable && in_valid) begin
          if (ftype == FLIT_HEAD) begin
            wr_en      = 1'b1;
            cnt_next   = ADDR_W'(1);
            acc_next   = payload;
            state_next = ST_RECV;
          end else begin
            code_next  = ERR_SEQ;
            state_next = ST_ERR;
          end
        end
      end
      ST_RECV: begin
        wr_addr = flit_cnt;
        if (in_valid) begin
          case (ftype)
            FLIT_BODY: begin
              if (flit_cnt < LAST_IDX) begin
                wr_en    = 1'b1;
                cnt_next = flit_cnt + ADDR_W'(1);
                acc_next = acc ^ payload;
              end else begin
                code_next  = ERR_LEN;
                state_next = ST_ERR;
              end
            end
            FLIT_TAIL: begin
              if (flit_cnt != LAST_IDX) begin
                code_next  = ERR_LEN;
                state_next = ST_ERR;
              end else if (payload == acc) begin
                wr_en      = 1'b1;
                cnt_next   = flit_cnt + ADDR_W'(1);
                state_next = ST_DONE;
              end else begin
                code_next  = ERR_CSUM;
                state_next = ST_ERR;
              end
            end
            default: begin
              code_next  = ERR_SEQ;
              state_next = ST_ERR;
            end
          endcase
        end
      end
      ST_DONE, ST_ERR: begin
        if (!enable) begin
          code_next  = ERR_NONE;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they can be registered
  always_comb begin
    done_next = (state_next == ST_DONE);
    err_next  = (state_next == ST_ERR);
    busy_next = (state_next == ST_RECV);
  end

  // Output and datapath registers, all cleared asynchronously
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rx_done  <= 1'b0;
      rx_err   <= 1'b0;
      busy     <= 1'b0;
      err_code <= ERR_NONE;
      flit_cnt <= '0;
      acc      <= '0;
    end else begin
      rx_done  <= done_next;
      rx_err   <= err_next;
      busy     <= busy_next;
      err_code <= code_next;
      flit_cnt <= cnt_next;
      acc      <= acc_next;
    end
  end

  datain_ram #(
    .WIDTH(FLIT_W),
    .DEPTH(PKT_LEN),
    .AW   (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst_n  (RST),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(datain),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_datain_buf.sv
// tb_datain_buf: scenario tasks plus randomized packets checked against a
// packet-level reference model of the receive rules.
module tb_datain_buf;

  localparam int LEN = 30;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_TAIL = 2'b01;
  localparam logic [1:0] T_HEAD = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic [19:0] datain = '0;
  logic        in_valid = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [19:0] rd_data;
  logic        rx_done;
  logic        rx_err;
  logic [1:0]  err_code;
  logic [4:0]  flit_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // Reference model: what the buffer should hold and the current flit count
  logic [19:0] model_mem [32];
  bit          model_valid [32];
  int          model_cnt = 0;

  datain_buf dut (
    .clk     (clk),
    .RST     (RST),
    .enable  (enable),
    .datain  (datain),
    .in_valid(in_valid),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .err_code(err_code),
    .flit_cnt(flit_cnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] status();
    return {rx_done, rx_err, err_code, flit_cnt, busy};
  endfunction

  function automatic logic [9:0] exp_status(input logic done, input logic err,
                                            input logic [1:0] code, input int cnt,
                                            input logic bsy);
    return {done, err, code, cnt[4:0], bsy};
  endfunction

  // Directed packet: head 0x80001, bodies 2..29, caller-chosen tail
  task automatic build_directed(input logic [19:0] tail, output logic [19:0] pkt[$]);
    pkt = {};
    pkt.push_back(20'h80001);
    for (int i = 2; i <= 29; i++) pkt.push_back(20'(i));
    pkt.push_back(tail);
  endtask

  // Random packet with a correct checksum, then one optional corruption
  task automatic build_packet(input int mode, output logic [19:0] pkt[$]);
    logic [17:0] acc, p;
    logic [19:0] tmp;
    int cut;
    pkt = {};
    p = 18'($urandom);
    pkt.push_back({T_HEAD, p});
    acc = p;
    for (int i = 1; i < LEN - 1; i++) begin
      p = 18'($urandom);
      pkt.push_back({T_BODY, p});
      acc = acc ^ p;
    end
    pkt.push_back({T_TAIL, acc});
    cut = $urandom_range(LEN - 2, 1);
    case (mode)
      1: begin tmp = pkt[LEN-1]; tmp[17:0] = acc ^ 18'($urandom_range(1000, 1)); pkt[LEN-1] = tmp; end
      2: begin tmp = pkt[cut]; tmp[19:18] = T_TAIL; pkt[cut] = tmp; end
      3: begin tmp = pkt[LEN-1]; tmp[19:18] = T_BODY; pkt[LEN-1] = tmp; end
      4: begin tmp = pkt[cut]; tmp[19:18] = T_HEAD; pkt[cut] = tmp; end
      5: begin tmp = pkt[cut]; tmp[19:18] = T_RSVD; pkt[cut] = tmp; end
      6: begin tmp = pkt[0]; tmp[19:18] = T_BODY; pkt[0] = tmp; end
      default: ;
    endcase
  endtask

  // Walks a packet flit by flit against the receive rules starting from an
  // armed idle receiver; didx is the flit that ends the packet (size if none)
  task automatic predict(input logic [19:0] pkt[$], output logic done,
                         output logic [1:0] code, output int didx);
    logic [17:0] acc, p;
    logic [1:0]  t;
    acc  = '0;
    done = 1'b0;
    code = 2'd0;
    didx = pkt.size();
    for (int i = 0; i < pkt.size(); i++) begin
      t = pkt[i][19:18];
      p = pkt[i][17:0];
      if (i == 0) begin
        if (t != T_HEAD) begin code = 2'd1; didx = 0; return; end
        model_mem[0] = pkt[0]; model_valid[0] = 1'b1; model_cnt = 1; acc = p;
      end else if (t == T_HEAD || t == T_RSVD) begin
        code = 2'd1; didx = i; return;
      end else if (t == T_BODY) begin
        if (i < LEN - 1) begin
          model_mem[i] = pkt[i]; model_valid[i] = 1'b1; model_cnt = i + 1; acc = acc ^ p;
        end else begin
          code = 2'd2; didx = i; return;
        end
      end else begin
        if (i != LEN - 1) begin code = 2'd2; didx = i; return; end
        if (p == acc) begin
          model_mem[i] = pkt[i]; model_valid[i] = 1'b1; model_cnt = LEN; done = 1'b1;
        end else begin
          code = 2'd3; model_valid[i] = 1'b0;
        end
        didx = i;
        return;
      end
    end
  endtask

  // Drives a packet with random idle gaps; busy must hold until the ending flit
  task automatic send_packet(input logic [19:0] pkt[$], input int gap_min, input int gap_max,
                             input int didx, input bit rf_check, input logic [19:0] rf_old);
    bit ok = 1'b1;
    for (int i = 0; i < pkt.size(); i++) begin
      datain   = pkt[i];
      in_valid = 1'b1;
      tick();
      if (i == 0 && rf_check) begin
        checks++;
        if (rd_data !== rf_old) begin
          errors++;
          $display("[TB] FAIL read_first: rd_data=%h expected %h", rd_data, rf_old);
        end
      end
      if (i < didx && (busy !== 1'b1 || rx_done !== 1'b0 || rx_err !== 1'b0)) ok = 1'b0;
      in_valid = 1'b0;
      datain   = 20'($urandom);
      repeat ($urandom_range(gap_max, gap_min)) begin
        tick();
        if (i < didx && (busy !== 1'b1 || rx_done !== 1'b0 || rx_err !== 1'b0)) ok = 1'b0;
      end
    end
    if (didx > 0) begin
      checks++;
      if (!ok) begin
        errors++;
        $display("[TB] FAIL busy_track: busy/done/err wrong while packet in flight, expected busy=1 done=0 err=0");
      end
    end
  endtask

  task automatic clear_to_idle();
    enable   = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (status() !== exp_status(1'b0, 1'b0, 2'd0, model_cnt, 1'b0)) begin
      errors++;
      $display("[TB] FAIL clear_idle: status=%h expected %h", status(), exp_status(1'b0, 1'b0, 2'd0, model_cnt, 1'b0));
    end
    enable = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (status() !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_async: status=%h expected 000", status());
    end
    tick();
    checks++;
    if (rd_data !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_rd_data: rd_data=%h expected 00000", rd_data);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (status() !== 10'h0) begin
      errors++;
      $display("[TB] FAIL reset_release: status=%h expected 000", status());
    end
    model_cnt = 0;
    for (int i = 0; i < 32; i++) model_valid[i] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    enable = 1'b1;
    build_directed(20'h40001, pkt);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 0, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_done: status=%h expected %h", status(), exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0));
    end
    rd_addr = 5'd0;  tick();
    checks++;
    if (rd_data !== 20'h80001) begin errors++; $display("[TB] FAIL rd_addr0: rd_data=%h expected 80001", rd_data); end
    rd_addr = 5'd29; tick();
    checks++;
    if (rd_data !== 20'h40001) begin errors++; $display("[TB] FAIL rd_addr29: rd_data=%h expected 40001", rd_data); end
    rd_addr = 5'd31; tick();
    checks++;
    if (rd_data !== 20'h0) begin errors++; $display("[TB] FAIL rd_addr31: rd_data=%h expected 00000", rd_data); end
    clear_to_idle();
  endtask

  task automatic test_gapped();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    build_directed(20'h40001, pkt);
    predict(pkt, done, code, didx);
    send_packet(pkt, 3, 3, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0)) begin
      errors++;
      $display("[TB] FAIL gapped_done: status=%h expected %h", status(), exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0));
    end
    clear_to_idle();
  endtask

  task automatic test_short_packet();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    build_directed(20'h40001, pkt);
    while (pkt.size() > 10) void'(pkt.pop_back());
    pkt.push_back(20'h40001);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 0, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b0, 1'b1, 2'd2, 10, 1'b0)) begin
      errors++;
      $display("[TB] FAIL short_len: status=%h expected %h", status(), exp_status(1'b0, 1'b1, 2'd2, 10, 1'b0));
    end
    clear_to_idle();
  endtask

  task automatic test_idle_errors();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    pkt = {};
    pkt.push_back(20'h00005);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 0, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b0, 1'b1, 2'd1, 10, 1'b0)) begin
      errors++;
      $display("[TB] FAIL idle_seq: status=%h expected %h", status(), exp_status(1'b0, 1'b1, 2'd1, 10, 1'b0));
    end
    clear_to_idle();
    enable   = 1'b0;
    datain   = 20'h00005;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (status() !== exp_status(1'b0, 1'b0, 2'd0, 10, 1'b0)) begin
      errors++;
      $display("[TB] FAIL idle_disabled: status=%h expected %h", status(), exp_status(1'b0, 1'b0, 2'd0, 10, 1'b0));
    end
    enable = 1'b1;
  endtask

  task automatic test_checksum();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    build_directed(20'h40000, pkt);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 1, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b0, 1'b1, 2'd3, 29, 1'b0)) begin
      errors++;
      $display("[TB] FAIL checksum: status=%h expected %h", status(), exp_status(1'b0, 1'b1, 2'd3, 29, 1'b0));
    end
    clear_to_idle();
  endtask

  task automatic test_done_head_race();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    build_directed(20'h40001, pkt);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 0, didx, 1'b0, 20'h0);
    enable   = 1'b0;
    datain   = 20'h80007;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (status() !== exp_status(1'b0, 1'b0, 2'd0, 30, 1'b0)) begin
      errors++;
      $display("[TB] FAIL race_head: status=%h expected %h", status(), exp_status(1'b0, 1'b0, 2'd0, 30, 1'b0));
    end
    enable  = 1'b1;
    rd_addr = 5'd0;
    tick();
    checks++;
    if (rd_data !== 20'h80001) begin
      errors++;
      $display("[TB] FAIL race_buf: rd_data=%h expected 80001", rd_data);
    end
  endtask

  task automatic test_reset_midpacket();
    logic [19:0] pkt[$], part[$];
    logic done; logic [1:0] code; int didx;
    build_packet(0, pkt);
    part = {};
    for (int i = 0; i < 14; i++) part.push_back(pkt[i]);
    predict(part, done, code, didx);
    send_packet(part, 0, 0, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b0, 1'b0, 2'd0, 14, 1'b1)) begin
      errors++;
      $display("[TB] FAIL mid_before: status=%h expected %h", status(), exp_status(1'b0, 1'b0, 2'd0, 14, 1'b1));
    end
    datain   = pkt[14];
    in_valid = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if (status() !== 10'h0 || rd_data !== 20'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: status=%h rd_data=%h expected 000 and 00000", status(), rd_data);
    end
    in_valid  = 1'b0;
    model_cnt = 0;
    tick();
    RST = 1'b1;
    tick();
    build_packet(0, pkt);
    predict(pkt, done, code, didx);
    send_packet(pkt, 0, 2, didx, 1'b0, 20'h0);
    checks++;
    if (status() !== exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0)) begin
      errors++;
      $display("[TB] FAIL mid_recover: status=%h expected %h", status(), exp_status(1'b1, 1'b0, 2'd0, 30, 1'b0));
    end
    clear_to_idle();
  endtask

  task automatic test_random();
    logic [19:0] pkt[$];
    logic done; logic [1:0] code; int didx;
    logic [19:0] old0; bit v0;
    int mode, addr;
    for (int n = 0; n < 24; n++) begin
      mode = (n < 4) ? 0 : $urandom_range(6, 0);
      build_packet(mode, pkt);
      rd_addr = 5'd0;
      old0 = model_mem[0];
      v0   = model_valid[0];
      predict(pkt, done, code, didx);
      send_packet(pkt, 0, 2, didx, v0, old0);
      checks++;
      if (status() !== exp_status(done, code != 2'd0, code, model_cnt, 1'b0)) begin
        errors++;
        $display("[TB] FAIL rand_status pkt %0d mode %0d: status=%h expected %h", n, mode,
                 status(), exp_status(done, code != 2'd0, code, model_cnt, 1'b0));
      end
      for (int k = 0; k < 4; k++) begin
        addr    = $urandom_range(31, 0);
        rd_addr = 5'(addr);
        tick();
        if (addr >= LEN || model_valid[addr]) begin
          checks++;
          if (rd_data !== ((addr >= LEN) ? 20'h0 : model_mem[addr])) begin
            errors++;
            $display("[TB] FAIL rand_read addr %0d: rd_data=%h expected %h", addr, rd_data,
                     (addr >= LEN) ? 20'h0 : model_mem[addr]);
          end
        end
      end
      clear_to_idle();
    end
  endtask

  initial begin
    $display("[TB] datain_buf bench starting");
    test_reset();
    test_back_to_back();
    test_gapped();
    test_short_packet();
    test_idle_errors();
    test_checksum();
    test_done_head_race();
    clear_to_idle();
    test_reset_midpacket();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
